// File: rtl/pwm_l2.sv
// pwm_l2 -- N-channel phase-shifted PWM modulator with complementary outputs
// and a programmable dead-time.
//
// A shared carrier counter advances on each ce strobe. Each channel compares
// a phase-shifted copy of that carrier against its own comparator value. The
// result drives a small FSM that inserts a dead interval between the two
// gate outputs of that channel.
//
// Runtime settings (period, comparator, phase, deadtime) are copied into
// shadow registers. This copy happens on every cycle while the modulator is
// idle, and only at the carrier wrap while it runs. A mid-frame change
// therefore never distorts the current frame.
//
// Ports:
//   aclk        clock
//   reset       synchronous, active-high reset
//   ce          carrier count enable, one aclk wide
//   enable      modulator run; low forces all gate outputs low
//   period      carrier period in ce ticks (counter runs 0..period-1)
//   comparator  per-channel duty compare, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
//   phase       per-channel carrier offset, same packing as comparator
//   deadtime    dead interval in aclk cycles, shared by all channels
//   pwm_h       high-side gate per channel
//   pwm_l       low-side gate per channel
//   sync        one-aclk pulse after each carrier wrap
module pwm_l2 #(
    parameter int N_CH      = 2,
    parameter int CNT_WIDTH = 32,
    parameter int DT_WIDTH  = 8
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      enable,
    input  logic [CNT_WIDTH-1:0]      period,
    input  logic [N_CH*CNT_WIDTH-1:0] comparator,
    input  logic [N_CH*CNT_WIDTH-1:0] phase,
    input  logic [DT_WIDTH-1:0]       deadtime,
    output logic [N_CH-1:0]           pwm_h,
    output logic [N_CH-1:0]           pwm_l,
    output logic                      sync
);

    localparam int CW = CNT_WIDTH;
    localparam logic [CW-1:0]       CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DT_WIDTH-1:0] DT_ONE  = {{(DT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        H_ON = 2'd1,
        L_ON = 2'd2,
        DEAD = 2'd3
    } ch_state_t;

    logic [CW-1:0]        cnt_reg;
    logic [CW-1:0]        period_s_reg;
    logic [N_CH*CW-1:0]   comparator_s_reg;
    logic [N_CH*CW-1:0]   phase_s_reg;
    logic [DT_WIDTH-1:0]  deadtime_s_reg;
    logic                 sync_reg;
    logic                 wrap;
    logic                 period_zero;
    logic                 dt_zero;

    assign period_zero = (period_s_reg == '0);
    assign dt_zero     = (deadtime_s_reg == '0);

    // A wrap is the ce edge on the last count of a non-empty period.
    // A zero period never wraps.
    assign wrap = enable & ce & ~period_zero & (cnt_reg == period_s_reg - CNT_ONE);

    always_ff @(posedge aclk) begin
        if (reset) begin
            cnt_reg          <= '0;
            period_s_reg     <= '0;
            comparator_s_reg <= '0;
            phase_s_reg      <= '0;
            deadtime_s_reg   <= '0;
            sync_reg         <= 1'b0;
        end else begin
            sync_reg <= wrap;

            if (!enable || wrap) begin
                period_s_reg     <= period;
                comparator_s_reg <= comparator;
                phase_s_reg      <= phase;
                deadtime_s_reg   <= deadtime;
            end

            if (!enable) begin
                cnt_reg <= '0;
            end else if (ce) begin
                if (period_zero || wrap) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    end

    assign sync = sync_reg;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CW-1:0]       cmp_s;
            logic [CW-1:0]       ph_s;
            logic [CW-1:0]       ph_eff;
            logic [CW:0]         sum;
            logic [CW:0]         diff;
            logic [CW-1:0]       ccnt;
            logic                raw_q_reg;
            ch_state_t           state_reg;
            logic [DT_WIDTH-1:0] dt_reg;
            logic                pwm_h_reg;
            logic                pwm_l_reg;

            assign cmp_s = comparator_s_reg[gi*CW +: CW];
            assign ph_s  = phase_s_reg[gi*CW +: CW];

            // An out-of-range phase collapses to zero. This keeps the
            // shifted carrier inside 0..period-1 with a single subtract.
            assign ph_eff = (ph_s >= period_s_reg) ? '0 : ph_s;
            assign sum    = {1'b0, cnt_reg} + {1'b0, ph_eff};
            assign diff   = sum - {1'b0, period_s_reg};
            assign ccnt   = (sum >= {1'b0, period_s_reg}) ? diff[CW-1:0] : sum[CW-1:0];

            always_ff @(posedge aclk) begin
                if (reset) begin
                    raw_q_reg <= 1'b0;
                end else begin
                    raw_q_reg <= enable & ~period_zero & (ccnt < cmp_s);
                end
            end

            // Gate FSM. dt_reg holds the number of dead cycles still to
            // serve, counting the current one. The FSM therefore leaves DEAD
            // once dt_reg reaches 1, which gives exactly deadtime_s cycles of
            // both gates low.
            //
            // The side that is entered is raw_q at exit time. This means a
            // raw pulse shorter than the dead interval is swallowed.
            //
            // Gate outputs are written together with the state, so they
            // stay registered. The two outputs are never both set.
            always_ff @(posedge aclk) begin
                if (reset) begin
                    state_reg <= OFF;
                    dt_reg    <= '0;
                    pwm_h_reg <= 1'b0;
                    pwm_l_reg <= 1'b0;
                end else if (!enable) begin
                    state_reg <= OFF;
                    dt_reg    <= '0;
                    pwm_h_reg <= 1'b0;
                    pwm_l_reg <= 1'b0;
                end else begin
                    case (state_reg)
                        OFF: begin
                            if (dt_zero) begin
                                state_reg <= raw_q_reg ? H_ON : L_ON;
                                pwm_h_reg <= raw_q_reg;
                                pwm_l_reg <= ~raw_q_reg;
                            end else begin
                                state_reg <= DEAD;
                                dt_reg    <= deadtime_s_reg;
                                pwm_h_reg <= 1'b0;
                                pwm_l_reg <= 1'b0;
                            end
                        end
                        H_ON: begin
                            if (!raw_q_reg) begin
                                pwm_h_reg <= 1'b0;
                                if (dt_zero) begin
                                    state_reg <= L_ON;
                                    pwm_l_reg <= 1'b1;
                                end else begin
                                    state_reg <= DEAD;
                                    dt_reg    <= deadtime_s_reg;
                                    pwm_l_reg <= 1'b0;
                                end
                            end
                        end
                        L_ON: begin
                            if (raw_q_reg) begin
                                pwm_l_reg <= 1'b0;
                                if (dt_zero) begin
                                    state_reg <= H_ON;
                                    pwm_h_reg <= 1'b1;
                                end else begin
                                    state_reg <= DEAD;
                                    dt_reg    <= deadtime_s_reg;
                                    pwm_h_reg <= 1'b0;
                                end
                            end
                        end
                        DEAD: begin
                            if (dt_reg <= DT_ONE) begin
                                state_reg <= raw_q_reg ? H_ON : L_ON;
                                dt_reg    <= '0;
                                pwm_h_reg <= raw_q_reg;
                                pwm_l_reg <= ~raw_q_reg;
                            end else begin
                                dt_reg <= dt_reg - DT_ONE;
                            end
                        end
                        default: begin
                            state_reg <= OFF;
                            dt_reg    <= '0;
                            pwm_h_reg <= 1'b0;
                            pwm_l_reg <= 1'b0;
                        end
                    endcase
                end
            end

            assign pwm_h[gi] = pwm_h_reg;
            assign pwm_l[gi] = pwm_l_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_l2.sv
// Testbench for pwm_l2.
//
// The bench applies directed segments from the test plan, followed by
// randomized segments. Inside the randomized segments it also makes random
// mid-frame setting changes, drops enable and pulses reset.
//
// The reference model works on integers:
//   - the phase-shifted carrier is (cnt + phase) mod period;
//   - each gate is a "driven side" (none / low / high) plus a count of dead
//     cycles still to serve.
module tb_pwm_l2;
    localparam int N_CH = 2;
    localparam int CW   = 32;
    localparam int DW   = 8;

    logic              aclk = 1'b0;
    logic              reset;
    logic              ce;
    logic              enable;
    logic [CW-1:0]     period;
    logic [N_CH*CW-1:0] comparator;
    logic [N_CH*CW-1:0] phase;
    logic [DW-1:0]     deadtime;
    logic [N_CH-1:0]   pwm_h;
    logic [N_CH-1:0]   pwm_l;
    logic              sync;

    always #5 aclk = ~aclk;

    pwm_l2 #(.N_CH(N_CH), .CNT_WIDTH(CW), .DT_WIDTH(DW)) dut (
        .aclk       (aclk),
        .reset      (reset),
        .ce         (ce),
        .enable     (enable),
        .period     (period),
        .comparator (comparator),
        .phase      (phase),
        .deadtime   (deadtime),
        .pwm_h      (pwm_h),
        .pwm_l      (pwm_l),
        .sync       (sync)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model state.
    // side: 0 = no gate driven, 1 = low side on, 2 = high side on.
    longint m_cnt, m_per, m_dts;
    longint m_cmp [N_CH];
    longint m_ph  [N_CH];
    bit     m_raw [N_CH];
    bit     m_sync;
    int     m_side[N_CH];
    int     m_dead[N_CH];

    function automatic void model_clear();
        m_cnt = 0; m_per = 0; m_dts = 0; m_sync = 0;
        for (int k = 0; k < N_CH; k++) begin
            m_cmp[k] = 0; m_ph[k] = 0; m_raw[k] = 0; m_side[k] = 0; m_dead[k] = 0;
        end
    endfunction

    // One aclk edge of the reference model, using the inputs applied before it.
    function automatic void model_step();
        bit     wrap;
        bit     raw_n[N_CH];
        longint ph;
        if (reset) begin
            model_clear();
            return;
        end
        wrap = enable && ce && (m_per != 0) && (m_cnt == m_per - 1);
        for (int k = 0; k < N_CH; k++) begin
            raw_n[k] = 0;
            if (enable && m_per != 0) begin
                ph = (m_ph[k] >= m_per) ? 0 : m_ph[k];
                raw_n[k] = (((m_cnt + ph) % m_per) < m_cmp[k]);
            end
        end
        // Gate sides are driven from the raw compare of the previous cycle.
        for (int k = 0; k < N_CH; k++) begin
            if (!enable) begin
                m_side[k] = 0; m_dead[k] = 0;
            end else if (m_dead[k] > 0) begin
                m_dead[k]--;
                if (m_dead[k] == 0) m_side[k] = m_raw[k] ? 2 : 1;
            end else if (m_side[k] == 0 || (m_side[k] == 2 && !m_raw[k]) ||
                         (m_side[k] == 1 && m_raw[k])) begin
                if (m_dts == 0) begin
                    m_side[k] = m_raw[k] ? 2 : 1;
                end else begin
                    m_side[k] = 0; m_dead[k] = int'(m_dts);
                end
            end
        end
        if (!enable) m_cnt = 0;
        else if (ce) m_cnt = (m_per == 0 || wrap) ? 0 : m_cnt + 1;
        if (!enable || wrap) begin
            m_per = period;
            m_dts = deadtime;
            for (int k = 0; k < N_CH; k++) begin
                m_cmp[k] = comparator[k*CW +: CW];
                m_ph[k]  = phase[k*CW +: CW];
            end
        end
        for (int k = 0; k < N_CH; k++) m_raw[k] = raw_n[k];
        m_sync = wrap;
    endfunction

    // Called at a negedge with inputs already set. Returns at the next negedge.
    task automatic run_cycle();
        @(posedge aclk);
        model_step();
        #1;
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("pwm_h[%0d]", k), longint'(pwm_h[k]), longint'(m_side[k] == 2));
            check($sformatf("pwm_l[%0d]", k), longint'(pwm_l[k]), longint'(m_side[k] == 1));
        end
        check("sync", longint'(sync), longint'(m_sync));
        check("overlap", longint'(pwm_h & pwm_l), 0);
        @(negedge aclk);
    endtask

    task automatic set_ch(input int c0, input int c1, input int p0, input int p1);
        comparator[0 +: CW]  = CW'(c0);
        comparator[CW +: CW] = CW'(c1);
        phase[0 +: CW]       = CW'(p0);
        phase[CW +: CW]      = CW'(p1);
    endtask

    int seg_no = 0;

    // One segment. mid_at >= 0 applies comparator ch0 = mid_c and
    // period = mid_per at that cycle. rst_at >= 0 pulses reset at that cycle.
    // chaos enables random changes to settings, enable and reset.
    task automatic run_seg(input int per, input int c0, input int c1, input int p0,
                           input int p1, input int dtv, input int ce_div, input int len,
                           input int mid_at, input int mid_c, input int mid_per,
                           input int rst_at, input bit chaos);
        int e0 = n_err;
        period   = CW'(per);
        deadtime = DW'(dtv);
        set_ch(c0, c1, p0, p1);
        enable = 1'b0; ce = 1'b0; reset = 1'b0;
        repeat (2) run_cycle();
        enable = 1'b1;
        for (int i = 0; i < len; i++) begin
            ce = ((i % ce_div) == 0);
            reset = (i == rst_at);
            if (i == mid_at) begin
                comparator[0 +: CW] = CW'(mid_c);
                period = CW'(mid_per);
            end
            if (chaos) begin
                if ($urandom_range(0, 49) == 0)
                    set_ch($urandom_range(0, per + 3), $urandom_range(0, per + 3),
                           $urandom_range(0, per + 4), $urandom_range(0, per + 4));
                if ($urandom_range(0, 99) == 0) period = CW'($urandom_range(0, 12));
                if ($urandom_range(0, 99) == 0) deadtime = DW'($urandom_range(0, 4));
                enable = ($urandom_range(0, 149) != 0);
                if ($urandom_range(0, 299) == 0) reset = 1'b1;
            end
            run_cycle();
        end
        $display("seg %0d: period=%0d cmp={%0d,%0d} phase={%0d,%0d} dt=%0d ce_div=%0d cycles=%0d mismatches=%0d",
                 seg_no, per, c0, c1, p0, p1, dtv, ce_div, len, n_err - e0);
        seg_no++;
    endtask

    initial begin
        model_clear();
        reset = 1'b1; enable = 1'b0; ce = 1'b0;
        period = '0; deadtime = '0; comparator = '0; phase = '0;
        @(negedge aclk);
        repeat (3) run_cycle();
        reset = 1'b0;

        // Directed segments from the test plan.
        run_seg(100, 50, 25,  0,  0, 0, 4, 900, -1,  0,   0,  -1, 0);
        run_seg(100, 50, 50,  0, 50, 0, 4, 900, -1,  0,   0,  -1, 0);
        run_seg(100, 40, 40,  0,  0, 3, 4, 900, -1,  0,   0,  -1, 0);
        run_seg(100, 50, 50,  0,  0, 0, 4, 900, 120, 80, 100, -1, 0);
        run_seg(100, 50, 50,  0,  0, 2, 4, 900, 150, 50,  50, -1, 0);
        run_seg(100,  0, 120, 0,  0, 0, 4, 500, -1,  0,   0,  -1, 0);
        run_seg(  0, 10, 10,  0,  0, 1, 1, 100, -1,  0,   0,  -1, 0);
        run_seg(100, 50, 50, 150, 0, 0, 4, 500, -1,  0,   0,  -1, 0);
        run_seg(100, 50, 50,  0,  0, 0, 4, 300, -1,  0,   0, 100, 0);
        run_seg(100, 50, 50,  0,  0, 3, 4, 300, -1,  0,   0, 203, 0);
        run_seg(  1,  1,  0,  0,  0, 0, 1, 100, -1,  0,   0,  -1, 0);

        // Randomized segments.
        for (int s = 0; s < 40; s++) begin
            int per = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            run_seg(per, $urandom_range(0, per + 3), $urandom_range(0, per + 3),
                    $urandom_range(0, per + 4), $urandom_range(0, per + 4),
                    $urandom_range(0, 4), $urandom_range(1, 4), $urandom_range(150, 300),
                    -1, 0, 0, -1, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_l2.md
Name: pwm_l2

Overview:
- Parametrised N-channel successor to the single-channel PWM modulator used in the converter models.
- A shared carrier counter advances on `ce`. Each channel compares a phase-shifted copy of the carrier against its own comparator value.
- Each channel drives complementary high/low outputs with programmable dead-time.
- Sits between the PI regulators and multi-leg converter models (interleaved boost, full-bridge). Runtime values are shadowed and take effect only at carrier wrap.

Parameters:
- N_CH, 2, number of channels.
- CNT_WIDTH, 32, width of carrier counter, period, comparator and phase.
- DT_WIDTH, 8, width of dead-time value, counted in aclk cycles.

Ports:
- aclk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  carrier count enable, one aclk wide.
- enable  in  1  modulator run; low forces all outputs low.
- period  in  CNT_WIDTH  carrier period in ce ticks; counter runs 0..period-1.
- comparator  in  N_CH*CNT_WIDTH  per-channel duty compare; channel k occupies bits [k*CNT_WIDTH +: CNT_WIDTH].
- phase  in  N_CH*CNT_WIDTH  per-channel carrier offset, same packing as comparator.
- deadtime  in  DT_WIDTH  dead-time in aclk cycles, common to all channels.
- pwm_h  out  N_CH  high-side gate per channel.
- pwm_l  out  N_CH  low-side gate per channel.
- sync  out  1  one-aclk pulse at each carrier wrap.

Behaviour:
- Reset (reset=1 at an aclk edge) clears the following on the same edge:
  - counter, shadows, raw_q and dead-time counters to 0;
  - channel FSMs to OFF;
  - pwm_h, pwm_l and sync to 0.
  - Reset mid-pulse or mid-dead-time aborts immediately; no completion of the dead interval.
- Shadow registers (period_s, comparator_s, phase_s, deadtime_s):
  - Loaded every aclk while enable=0.
  - While enable=1, loaded only on the wrap edge (ce=1 and cnt==period_s-1), together with cnt<=0.
  - Mid-period input changes have no effect until the next wrap.
- Carrier counter:
  - On ce=1 with enable=1: cnt<=cnt+1, or cnt<=0 at wrap.
  - Held when ce=0; held at 0 when enable=0.
  - period_s==0: cnt held at 0, no wraps, all raw outputs 0.
  - period_s==1: wraps on every ce.
- sync: registered, 1 on the aclk after each wrap edge, else 0.
- Per-channel carrier: ph=phase_s[k]; if ph>=period_s then ph is treated as 0.
  - s=cnt+ph computed in CNT_WIDTH+1 bits.
  - ccnt = s>=period_s ? s-period_s : s.
- Raw compare: raw_q[k] <= enable & (period_s!=0) & (ccnt < comparator_s[k]), registered one aclk after the counter.
  - comparator_s[k]==0 gives 0% duty.
  - comparator_s[k]>=period_s gives 100% duty (raw constantly 1).
- Channel FSM, one per channel (states OFF, H_ON, L_ON, DEAD), with target side tgt and down-counter dt:
  - OFF: both outputs 0.
    - Goes to DEAD (tgt=raw_q, dt=deadtime_s) when enable=1.
    - If deadtime_s==0, goes straight to H_ON or L_ON per raw_q.
  - H_ON (pwm_h=1, pwm_l=0): on raw_q==0, goes to DEAD with tgt=L, dt=deadtime_s, or directly to L_ON if deadtime_s==0.
  - L_ON (pwm_h=0, pwm_l=1): symmetric; on raw_q==1, goes toward H.
  - DEAD: both outputs 0; dt decrements each aclk.
    - tgt follows raw_q each cycle; dt is not restarted.
    - When dt==0, goes to the state for tgt.
    - Pulses shorter than the dead-time are therefore swallowed.
  - Any state goes to OFF on enable=0, on the next edge.
- Outputs are registered FSM decodes. pwm_h and pwm_l are never both 1 in any cycle, including reset, enable toggling and deadtime_s==0.
- Latency:
  - raw edge = ce edge + 1 aclk.
  - Output edge = raw edge + 1 aclk when deadtime=0.
  - Output edge = raw edge + deadtime_s + 1 aclk for the incoming side. The outgoing side drops 1 aclk after the raw edge.

Test Plan:
- ce every 4 aclk, N_CH=2, period=100, comparator={50,25}, phase={0,0}, deadtime=0 -> ch0 high for 50 ce, ch1 high for 25 ce per 100-ce frame; pwm_l exactly complements pwm_h; sync pulses every 400 aclk.
- Same setup with phase={0,50}, comparator={50,50} -> ch1 pwm_h rising edge lags ch0 by 50 ce (200 aclk); the two channels never high simultaneously.
- deadtime=3, comparator=40 -> at each transition both outputs are low for exactly 3 aclk; pwm_h high for 40*4-3 aclk per frame; no cycle with both outputs 1.
- Change comparator 50->80 at cnt=30 -> the current frame still ends its high time at cnt=50; the next frame holds high until cnt=80. Change period 100->50 mid-frame -> takes effect only after the wrap.
- Boundaries: comparator=0 -> pwm_h=0 and pwm_l=1 constant; comparator=120 with period=100 -> pwm_h=1 constant; period=0 -> raw 0 and no sync; phase=150 -> behaves as phase 0.
- Assert reset while pwm_h=1 and while in DEAD -> all outputs, sync and cnt are 0 on the next edge. enable=0 -> outputs low next edge. enable re-raised -> deadtime_s cycles of both low before the first gate goes high.
